// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: start/done handshake, operands and result bus for the digit-serial adder
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract, DIGIT bits per clock through a ripple slice and registered carry
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                clk,
  input logic                rst_n,
  digit_serial_adder_if.slave io
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic                   c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT:0]         c;
  logic [DIGIT-1:0]       s;
  logic [WIDTH+DIGIT-1:0] cat;
  logic                   run, last, load, fin;
  assign c[0] = c_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a_q[i] ^ b_q[i] ^ c[i];
    assign c[i+1] = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
  end
  assign cat  = {s, acc_q};
  assign run  = state_q == RUN;
  assign last = cnt_q == CW'(NDIG - 1);
  assign fin  = run && last;
  assign load = (state_q == IDLE || state_q == DONE) && io.start;
  // Subtraction is a + ~b + 1: invert b at load and force the initial carry to 1.
  always_comb begin
    state_d = load ? RUN : (run ? (last ? DONE : RUN) : IDLE);
    cnt_d   = load ? '0 : (run ? cnt_q + 1'b1 : cnt_q);
    a_d     = load ? io.a : (run ? a_q >> DIGIT : a_q);
    b_d     = load ? io.b ^ {WIDTH{io.sub}} : (run ? b_q >> DIGIT : b_q);
    c_d     = load ? (io.sub | io.cin) : (run ? c[DIGIT] : c_q);
    acc_d   = run ? cat[WIDTH+DIGIT-1:DIGIT] : acc_q;
    sum_d   = fin ? cat[WIDTH+DIGIT-1:DIGIT] : sum_q;
    cout_d  = fin ? c[DIGIT] : cout_q;
    ovf_d   = fin ? c[DIGIT] ^ c[DIGIT-1] : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign io.busy = run;
  assign io.done = state_q == DONE;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;
endmodule
